// File: rtl/bcd_scan_display.sv
// Multi-digit BCD up/down counter with prescaled tick and a scanned common-anode display drive.
// Optional leading-zero blanking is enabled by defining BCD_SCAN_LZB_EN.
module bcd_scan_display #(
    parameter int NUM_DIGITS = 4,
    parameter int TICK_DIV   = 100000000,
    parameter int SCAN_DIV   = 100000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic                    up_dn,
    input  logic                    clr,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] load_val,
    output logic [4*NUM_DIGITS-1:0] count_bcd,
    output logic                    wrap,
    output logic [6:0]              seg,
    output logic [NUM_DIGITS-1:0]   an
);

    localparam int W  = 4 * NUM_DIGITS;
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [PW-1:0] PRE_MAX  = PW'(TICK_DIV - 1);
    localparam logic [SW-1:0] SCAN_MAX = SW'(SCAN_DIV - 1);
    localparam logic [IW-1:0] IDX_MAX  = IW'(NUM_DIGITS - 1);

    function automatic logic [6:0] glyph(input logic [3:0] d);
        case (d)
            4'd0:    glyph = 7'b1000000;
            4'd1:    glyph = 7'b1111001;
            4'd2:    glyph = 7'b0100100;
            4'd3:    glyph = 7'b0110000;
            4'd4:    glyph = 7'b0011001;
            4'd5:    glyph = 7'b0010010;
            4'd6:    glyph = 7'b0000010;
            4'd7:    glyph = 7'b1111000;
            4'd8:    glyph = 7'b0000000;
            4'd9:    glyph = 7'b0011000;
            default: glyph = 7'b1111111;
        endcase
    endfunction

    logic [PW-1:0] pre;
    logic [SW-1:0] tmr;
    logic [IW-1:0] idx;
    logic          tick;
    logic [W-1:0]  inc_val;
    logic [W-1:0]  dec_val;
    logic [W-1:0]  ld_val;
    logic          carry;
    logic          borrow;
    logic [3:0]    dig;

    assign tick = en && (pre == PRE_MAX);

    // Ripple carry/borrow across digits; a carry or borrow out of the top means wrap.
    always_comb begin
        inc_val = '0;
        dec_val = '0;
        ld_val  = '0;
        carry   = 1'b1;
        borrow  = 1'b1;
        dig     = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            dig = count_bcd[4*i +: 4];
            if (carry) begin
                inc_val[4*i +: 4] = (dig == 4'd9) ? 4'd0 : dig + 4'd1;
                carry = (dig == 4'd9);
            end else begin
                inc_val[4*i +: 4] = dig;
            end
            if (borrow) begin
                dec_val[4*i +: 4] = (dig == 4'd0) ? 4'd9 : dig - 4'd1;
                borrow = (dig == 4'd0);
            end else begin
                dec_val[4*i +: 4] = dig;
            end
            ld_val[4*i +: 4] = (load_val[4*i +: 4] > 4'd9) ? 4'd0 : load_val[4*i +: 4];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_bcd <= '0;
            pre       <= '0;
            wrap      <= 1'b0;
        end else begin
            wrap <= 1'b0;
            if (clr) begin
                count_bcd <= '0;
                pre       <= '0;
            end else if (load) begin
                count_bcd <= ld_val;
                pre       <= '0;
            end else if (en) begin
                if (tick) begin
                    pre       <= '0;
                    count_bcd <= up_dn ? inc_val : dec_val;
                    wrap      <= up_dn ? carry : borrow;
                end else begin
                    pre <= pre + 1'b1;
                end
            end
        end
    end

    logic [NUM_DIGITS-1:0] an_d;
    logic [3:0]            dsel;
    logic [6:0]            seg_d;

`ifdef BCD_SCAN_LZB_EN
    logic nz;
    always_comb begin
        an_d = '1;
        dsel = '0;
        nz   = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            an_d[i] = (idx != IW'(i));
            if (idx == IW'(i))
                dsel = count_bcd[4*i +: 4];
            if (IW'(i) >= idx && count_bcd[4*i +: 4] != 4'd0)
                nz = 1'b1;
        end
        seg_d = ((idx != '0) && !nz) ? 7'b1111111 : glyph(dsel);
    end
`else
    always_comb begin
        an_d = '1;
        dsel = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            an_d[i] = (idx != IW'(i));
            if (idx == IW'(i))
                dsel = count_bcd[4*i +: 4];
        end
        seg_d = glyph(dsel);
    end
`endif

    // an and seg share one register stage so the digit and glyph switch together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmr <= '0;
            idx <= '0;
            an  <= '1;
            seg <= 7'b1111111;
        end else begin
            if (tmr == SCAN_MAX) begin
                tmr <= '0;
                idx <= (idx == IDX_MAX) ? '0 : idx + 1'b1;
            end else begin
                tmr <= tmr + 1'b1;
            end
            an  <= an_d;
            seg <= seg_d;
        end
    end

endmodule

// File: tb/tb_bcd_scan_display.sv
// Randomised self-checking bench for bcd_scan_display against an integer-valued reference model.
module tb_bcd_scan_display;

    localparam int N    = 2;
    localparam int TD   = 4;
    localparam int SD   = 2;
    localparam int MAXV = 99;
    localparam int VW   = 4*N + 1 + N + 7;

    localparam logic [6:0] GLYPH [10] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
        7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0011000
    };

    logic           clk = 0;
    logic           rst = 1;
    logic           en = 0;
    logic           up_dn = 1;
    logic           clr = 0;
    logic           load = 0;
    logic [4*N-1:0] load_val = '0;
    logic [4*N-1:0] count_bcd;
    logic           wrap;
    logic [6:0]     seg;
    logic [N-1:0]   an;

    int checks = 0;
    int errors = 0;

    int         m_val, m_pre, m_idx, m_tmr;
    logic       m_wrap;
    logic [N-1:0] m_an;
    logic [6:0] m_seg;

    bcd_scan_display #(.NUM_DIGITS(N), .TICK_DIV(TD), .SCAN_DIV(SD)) dut (
        .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .clr(clr),
        .load(load), .load_val(load_val), .count_bcd(count_bcd),
        .wrap(wrap), .seg(seg), .an(an)
    );

    always #5 clk = ~clk;

    wire [VW-1:0] obs = {count_bcd, wrap, an, seg};

    function automatic logic [4*N-1:0] to_bcd(input int v);
        logic [4*N-1:0] r;
        r = '0;
        for (int i = 0; i < N; i++)
            r[4*i +: 4] = 4'((v / (10**i)) % 10);
        return r;
    endfunction

    function automatic int from_load(input logic [4*N-1:0] lv);
        int v, d;
        v = 0;
        for (int i = 0; i < N; i++) begin
            d = int'(lv[4*i +: 4]);
            if (d > 9) d = 0;
            v += d * (10**i);
        end
        return v;
    endfunction

    function automatic logic [VW-1:0] exp_vec();
        return {to_bcd(m_val), m_wrap, m_an, m_seg};
    endfunction

    task automatic model_reset();
        m_val = 0; m_pre = 0; m_idx = 0; m_tmr = 0;
        m_wrap = 0; m_an = '1; m_seg = 7'b1111111;
    endtask

    // Advance the model by one clock using the current inputs, then clock the DUT.
    task automatic step();
        int  dig;
        logic bl;
        dig = (m_val / (10**m_idx)) % 10;
        bl = 1'b0;
`ifdef BCD_SCAN_LZB_EN
        bl = (m_idx > 0) && (m_val < 10**m_idx);
`endif
        for (int i = 0; i < N; i++) m_an[i] = (i != m_idx);
        m_seg  = bl ? 7'b1111111 : GLYPH[dig];
        m_wrap = 1'b0;
        if (clr) begin
            m_val = 0; m_pre = 0;
        end else if (load) begin
            m_val = from_load(load_val); m_pre = 0;
        end else if (en) begin
            if (m_pre == TD - 1) begin
                m_pre = 0;
                if (up_dn) begin
                    m_wrap = (m_val == MAXV);
                    m_val  = (m_val + 1) % (MAXV + 1);
                end else begin
                    m_wrap = (m_val == 0);
                    m_val  = (m_val == 0) ? MAXV : m_val - 1;
                end
            end else begin
                m_pre++;
            end
        end
        if (m_tmr == SD - 1) begin
            m_tmr = 0;
            m_idx = (m_idx + 1) % N;
        end else begin
            m_tmr++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1; en = 0; clr = 0; load = 0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (obs !== {8'h00, 1'b0, 2'b11, 7'b1111111}) begin
            errors++;
            $display("FAIL reset_state got=%h want=%h", obs, {8'h00, 1'b0, 2'b11, 7'b1111111});
        end
        rst = 0;
        model_reset();
        step();
        checks++;
        if (an !== 2'b10 || seg !== 7'b1000000) begin
            errors++;
            $display("FAIL first_scan an=%b seg=%b want an=10 seg=1000000", an, seg);
        end
    endtask

    task automatic test_count_up();
        int wraps;
        wraps = 0;
        en = 1; up_dn = 1;
        for (int c = 0; c < 404; c++) begin
            step();
            checks++;
            if (obs !== exp_vec()) begin
                errors++;
                $display("FAIL count_up cyc=%0d got=%h want=%h", c, obs, exp_vec());
            end
            if (wrap) begin
                wraps++;
                checks++;
                if (count_bcd !== 8'h00) begin
                    errors++;
                    $display("FAIL up_wrap_value got=%h want=00", count_bcd);
                end
            end
        end
        checks++;
        if (wraps != 1) begin
            errors++;
            $display("FAIL up_wrap_count got=%0d want=1", wraps);
        end
    endtask

    task automatic test_count_down();
        int seen;
        seen = 0;
        clr = 1; step(); clr = 0;
        up_dn = 0; en = 1;
        for (int c = 0; c < 8; c++) begin
            step();
            checks++;
            if (obs !== exp_vec()) begin
                errors++;
                $display("FAIL count_down cyc=%0d got=%h want=%h", c, obs, exp_vec());
            end
            if (wrap && count_bcd === 8'h99) seen++;
        end
        checks++;
        if (seen != 1) begin
            errors++;
            $display("FAIL down_wrap got=%0d want=1", seen);
        end
        load = 1; load_val = 8'h90; step(); load = 0;
        repeat (4) step();
        checks++;
        if (count_bcd !== 8'h89) begin
            errors++;
            $display("FAIL borrow_ripple got=%h want=89", count_bcd);
        end
    endtask

    task automatic test_load_clr();
        en = 1; up_dn = 1;
        load = 1; load_val = 8'h5C; step(); load = 0;
        checks++;
        if (count_bcd !== 8'h50) begin
            errors++;
            $display("FAIL load_sanitize got=%h want=50", count_bcd);
        end
        step(); step();
        clr = 1; load = 1; load_val = 8'h37; step(); clr = 0; load = 0;
        checks++;
        if (count_bcd !== 8'h00 || wrap !== 1'b0) begin
            errors++;
            $display("FAIL clr_priority got=%h/%b want=00/0", count_bcd, wrap);
        end
        repeat (3) step();
        checks++;
        if (count_bcd !== 8'h00) begin
            errors++;
            $display("FAIL tick_early got=%h want=00", count_bcd);
        end
        step();
        checks++;
        if (count_bcd !== 8'h01) begin
            errors++;
            $display("FAIL tick_after_clr got=%h want=01", count_bcd);
        end
    endtask

    task automatic test_en_freeze();
        en = 1; up_dn = 1;
        step(); step();
        en = 0;
        for (int c = 0; c < 10; c++) begin
            step();
            checks++;
            if (obs !== exp_vec()) begin
                errors++;
                $display("FAIL en_freeze cyc=%0d got=%h want=%h", c, obs, exp_vec());
            end
        end
        en = 1;
        for (int c = 0; c < 12; c++) begin
            step();
            checks++;
            if (obs !== exp_vec()) begin
                errors++;
                $display("FAIL en_resume cyc=%0d got=%h want=%h", c, obs, exp_vec());
            end
        end
    endtask

    task automatic test_scan();
        logic [N-1:0] prev;
        int run;
        logic [6:0] want;
        en = 0;
        load = 1; load_val = 8'h07; step(); load = 0;
        step();
        prev = an; run = 0;
        for (int c = 0; c < 12; c++) begin
            step();
`ifdef BCD_SCAN_LZB_EN
            want = (an == 2'b10) ? 7'b1111000 : 7'b1111111;
`else
            want = (an == 2'b10) ? 7'b1111000 : 7'b1000000;
`endif
            checks++;
            if ((an !== 2'b10 && an !== 2'b01) || seg !== want) begin
                errors++;
                $display("FAIL scan_glyph an=%b seg=%b want_seg=%b", an, seg, want);
            end
            run++;
            if (an !== prev) begin
                checks++;
                if (run != 2 && c > 1) begin
                    errors++;
                    $display("FAIL scan_hold got=%0d want=2", run);
                end
                run = 0;
                prev = an;
            end
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            en       = ($urandom % 4) != 0;
            up_dn    = $urandom % 2;
            clr      = ($urandom % 32) == 0;
            load     = ($urandom % 16) == 0;
            load_val = 8'($urandom);
            step();
            checks++;
            if (obs !== exp_vec()) begin
                errors++;
                $display("FAIL random cyc=%0d got=%h want=%h", c, obs, exp_vec());
            end
        end
        clr = 0; load = 0;
    endtask

    task automatic test_async_reset();
        en = 0;
        load = 1; load_val = 8'h42; step(); load = 0;
        step(); step(); step();
        #2 rst = 1;
        #1;
        checks++;
        if (obs !== {8'h00, 1'b0, 2'b11, 7'b1111111}) begin
            errors++;
            $display("FAIL async_reset got=%h want=%h", obs, {8'h00, 1'b0, 2'b11, 7'b1111111});
        end
        @(posedge clk);
        #1 rst = 0;
        model_reset();
        for (int c = 0; c < 6; c++) begin
            step();
            checks++;
            if (obs !== exp_vec()) begin
                errors++;
                $display("FAIL post_reset cyc=%0d got=%h want=%h", c, obs, exp_vec());
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_count_up();
        test_count_down();
        test_load_clr();
        test_en_freeze();
        test_scan();
        test_random();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bcd_scan_display.md
Name: bcd_scan_display

Overview:
- Parametrised successor to the single-digit counter/decoder pair.
- NUM_DIGITS-wide decimal up/down counter with prescaled count tick, synchronous clear and parallel load.
- Time-multiplexed scan drive for a common-anode multi-digit seven-segment display.
- Sits between board clock/buttons and the display pins; also exports the BCD value and a wrap pulse to other logic.

Parameters:
- NUM_DIGITS, 4, number of BCD digits and display positions (1..8).
- TICK_DIV, 100000000, clk cycles per count step (>=1).
- SCAN_DIV, 100000, clk cycles each digit is driven before the scan advances (>=1).

Ports:
- clk  in  1  single system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  count enable; low freezes prescaler and counter.
- up_dn  in  1  1 = count up, 0 = count down.
- clr  in  1  synchronous clear of counter and prescaler.
- load  in  1  synchronous parallel load.
- load_val  in  4*NUM_DIGITS  BCD load value; nibble 0 is the least significant digit.
- count_bcd  out  4*NUM_DIGITS  current counter value.
- wrap  out  1  one-cycle pulse when the counter wraps.
- seg  out  7  active-low segments, bit6..bit0 = g..a.
- an  out  NUM_DIGITS  active-low digit enables; bit 0 = rightmost digit.

Behaviour:
- Reset (async, immediate): count_bcd=0, prescaler=0, wrap=0, scan index=0, scan timer=0, an=all 1 (all off), seg=7'b1111111.
- Counter priority per cycle: clr > load > tick.
  - clr: counter=0 and prescaler=0.
  - load: counter=load_val and prescaler=0. Any nibble >9 loads as 0.
- Prescaler:
  - Counts 0..TICK_DIV-1 only while en=1; holds while en=0.
  - tick asserts for one cycle when it is at TICK_DIV-1 with en=1; prescaler then returns to 0.
  - TICK_DIV=1 gives a tick every enabled cycle.
- Tick with up_dn=1: BCD increment with ripple carry (digit 9 -> 0 with carry). All-9s -> all-0s, wrap=1.
- Tick with up_dn=0: BCD decrement with ripple borrow (digit 0 -> 9 with borrow). All-0s -> all-9s, wrap=1.
- wrap is registered: high exactly the cycle after the wrapping tick edge, else 0. Never asserted by clr or load.
- count_bcd is registered and updates on the same edge as the tick/clr/load.
- Scan:
  - Timer counts 0..SCAN_DIV-1 continuously, independent of en/clr/load.
  - At SCAN_DIV-1 the index advances; index NUM_DIGITS-1 wraps to 0.
- Display outputs:
  - an and seg are registered from the current index and count_bcd: one cycle latency, and both always change on the same edge (no ghosting).
  - an is one-hot low at the index position.
  - seg follows the team decoder glyph table: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0011000.
- First posedge after rst deasserts: an=...1110, seg shows digit 0.
- Reset mid-scan or mid-count: all state returns to reset values immediately; no partial glyph remains.

Optional Feature:
- Macro: BCD_SCAN_LZB_EN.
- Defined: leading-zero blanking.
  - Any digit position above the most significant nonzero digit drives seg=1111111, with an still asserted as normal.
  - Digit 0 is never blanked, so value 0 shows a single "0".
  - Blanking is evaluated from the same count_bcd sample used for the glyph.
- Undefined: all digits are always displayed, including leading zeros.

Test Plan:
- NUM_DIGITS=2, TICK_DIV=4, en=1, up_dn=1 from reset -> count_bcd increments every 4 cycles: 00,01..09,10; after 99 -> 00 with wrap high exactly 1 cycle.
- Same config, up_dn=0 from 00 -> 99 and wrap pulse. Then 90 -> 89, checking borrow ripple.
- load=1, load_val=8'h5C, clr=0 -> count_bcd=8'h50. Then clr and load both high -> count_bcd=00, prescaler restarts, next tick 4 cycles later.
- en toggled low for 10 cycles mid-prescale -> count_bcd and tick timing frozen; resumes at the held prescaler phase.
- SCAN_DIV=2, count_bcd=8'h07 -> an sequence 10,01 each held 2 cycles. seg=1111000 with an=10, and seg=1000000 with an=01 (or 1111111 with BCD_SCAN_LZB_EN); an and seg change on the same edge.
- Assert rst asynchronously mid-scan at count 8'h42 -> an=11 and seg=1111111 immediately, count_bcd=00, wrap=0 before the next clk edge.
